// File: rtl/adder_tree_sequencer_pkg.sv
// Shared definitions for the adder-tree sequencer: tree width, float constants
// and the sequencer FSM state encoding.
package adder_tree_sequencer_pkg;

    localparam int unsigned NI = 8;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_FIRE,
        S_WAIT_T,
        S_ACC,
        S_WAIT_A,
        S_NEXT,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/adder_tree_sequencer_if.sv
// Buffer-read and adder-tree handshake bundle.
//   master (sequencer): drives rd_en, rd_addr, tree_inputs, tree_start;
//                       receives rd_data, tree_sum, tree_finish.
//   slave  (buffer + tree): the mirror image.
interface adder_tree_sequencer_if #(
    parameter int unsigned NI = 8,
    parameter int unsigned CW = 8
);
    logic               rd_en;
    logic [CW-1:0]      rd_addr;
    logic [NI*32-1:0]   rd_data;
    logic [NI*32-1:0]   tree_inputs;
    logic               tree_start;
    logic [31:0]        tree_sum;
    logic               tree_finish;

    modport master (
        output rd_en, rd_addr, tree_inputs, tree_start,
        input  rd_data, tree_sum, tree_finish
    );

    modport slave (
        input  rd_en, rd_addr, tree_inputs, tree_start,
        output rd_data, tree_sum, tree_finish
    );
endinterface

// File: rtl/adder_subtractor_with_start.sv
// Single-precision floating-point adder/subtractor with start/finish handshake.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle request; a, b, sub sampled on this cycle
//   a, b       : IEEE-754 single operands
//   sub        : 1 computes a - b, 0 computes a + b
//   sum        : result, valid while finish is high and held afterwards
//   finish     : one-cycle pulse the cycle after start
// Round-to-nearest-even; denormals flush to zero, overflow saturates to inf.
module adder_subtractor_with_start (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        finish
);
    logic [31:0] bb, x, y, res;
    logic [7:0]  d;
    logic [26:0] mx, my, myal;
    logic [53:0] wide;
    logic [27:0] r;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found, rnd;
    logic [30:0] mag;

    always_comb begin
        bb = {b[31] ^ sub, b[30:0]};
        // x always carries the larger magnitude so the aligned difference is non-negative
        if (a[30:0] >= bb[30:0]) begin
            x = a;
            y = bb;
        end else begin
            x = bb;
            y = a;
        end
        mx   = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0], 3'b000};
        my   = (y[30:23] == 8'd0) ? '0 : {1'b1, y[22:0], 3'b000};
        d    = x[30:23] - y[30:23];
        wide = {my, 27'd0} >> d;
        // bits shifted past the guard position collapse into the sticky bit
        myal = {wide[53:28], wide[27] | (|wide[26:0])};
        if (x[31] == y[31]) r = {1'b0, mx} + {1'b0, myal};
        else                r = {1'b0, mx} - {1'b0, myal};
        e     = {2'b00, x[30:23]};
        lz    = '0;
        found = 1'b0;
        if (r[27]) begin
            r = {1'b0, r[27:2], r[1] | r[0]};
            e = e + 10'd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++) begin
                if (!found && r[26 - i]) begin
                    lz    = 5'(i);
                    found = 1'b1;
                end
            end
            r = r << lz;
            e = e - {5'b00000, lz};
        end
        rnd = r[2] & (r[1] | r[0] | r[3]);
        // hidden bit dropped: a rounding carry out of the fraction bumps the exponent
        mag = {e[7:0], r[25:3]} + 31'(rnd);
        if (r == '0 || e[9] || e == 10'd0)
            res = '0;
        else if (e >= 10'd255 || mag[30:23] == 8'hFF)
            res = {x[31], 8'hFF, 23'd0};
        else
            res = {x[31], mag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum    <= '0;
            finish <= 1'b0;
        end else begin
            finish <= start;
            if (start) sum <= res;
        end
    end
endmodule

// File: rtl/adder_tree_sequencer.sv
// Initiator for the 8-input floating-point adder tree. Reduces num_chunks
// chunks of NI floats, read one chunk per request from a synchronous-read
// buffer, into a single float accumulated strictly in chunk order.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle request, accepted only when idle
//   num_chunks : chunks to reduce, latched on accepted start
//   bus        : buffer read port and tree start/finish handshake (master)
//   result     : final sum, held until next accepted start
//   busy       : high from accepted start until done/error
//   done       : one-cycle pulse, result valid
//   error      : one-cycle pulse on watchdog abort
module adder_tree_sequencer #(
    parameter int unsigned NI      = adder_tree_sequencer_pkg::NI,
    parameter int unsigned CW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CW-1:0]           num_chunks,
    adder_tree_sequencer_if.master  bus,
    output logic [31:0]             result,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    import adder_tree_sequencer_pkg::*;

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    seq_state_t     state;
    logic [CW-1:0]  nc, idx;
    logic [31:0]    acc, tsum, add_sum;
    logic           add_start, add_finish, add_finish_q, tree_finish_q;
    logic           tree_evt, add_evt;
    logic [WDW-1:0] wd;

    assign tree_evt = bus.tree_finish & ~tree_finish_q;
    assign add_evt  = add_finish & ~add_finish_q;

    adder_subtractor_with_start u_acc_add (
        .clk    (clk),
        .reset  (reset),
        .start  (add_start),
        .a      (acc),
        .b      (tsum),
        .sub    (1'b0),
        .sum    (add_sum),
        .finish (add_finish)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            nc              <= '0;
            idx             <= '0;
            acc             <= FP_ZERO;
            tsum            <= '0;
            wd              <= '0;
            add_start       <= 1'b0;
            add_finish_q    <= 1'b0;
            tree_finish_q   <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
            bus.tree_inputs <= '0;
            bus.tree_start  <= 1'b0;
            result          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            tree_finish_q  <= bus.tree_finish;
            add_finish_q   <= add_finish;
            bus.rd_en      <= 1'b0;
            bus.tree_start <= 1'b0;
            add_start      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            // strobes are registered on entry so they are high during their own state
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        nc   <= num_chunks;
                        idx  <= '0;
                        acc  <= FP_ZERO;
                        busy <= 1'b1;
                        if (num_chunks == '0) begin
                            state <= S_DONE;
                        end else begin
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= '0;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    bus.tree_inputs <= bus.rd_data;
                    bus.tree_start  <= 1'b1;
                    state           <= S_FIRE;
                end
                S_FIRE: begin
                    // the start cycle counts as the first waited cycle
                    wd    <= WDW'(1);
                    state <= S_WAIT_T;
                end
                S_WAIT_T: begin
                    if (tree_evt) begin
                        tsum  <= bus.tree_sum;
                        state <= S_ACC;
                    end else if (wd == WD_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                S_ACC: begin
                    if (idx == '0) begin
                        acc   <= tsum;
                        state <= S_NEXT;
                    end else begin
                        add_start <= 1'b1;
                        wd        <= WDW'(1);
                        state     <= S_WAIT_A;
                    end
                end
                S_WAIT_A: begin
                    if (add_evt) begin
                        acc   <= add_sum;
                        state <= S_NEXT;
                    end else if (wd == WD_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                S_NEXT: begin
                    idx <= idx + CW'(1);
                    if (idx + CW'(1) == nc) begin
                        state <= S_DONE;
                    end else begin
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= idx + CW'(1);
                        state       <= S_FETCH;
                    end
                end
                S_DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer with a buffer model and a
// configurable adder-tree model (latency, finish hold, never-finish).
module tb_adder_tree_sequencer;
    import adder_tree_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_chunks = '0;
    logic [31:0] result;
    logic        busy, done, error;

    adder_tree_sequencer_if #(.NI(8), .CW(8)) bus ();

    adder_tree_sequencer #(.NI(8), .CW(8), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_chunks (num_chunks),
        .bus        (bus),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer model: each chunk holds one word replicated across all lanes.
    logic [31:0] buf_word [4];
    initial begin
        bus.rd_data = '0;
        for (int i = 0; i < 4; i++) buf_word[i] = '0;
    end
    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= {8{buf_word[bus.rd_addr[1:0]]}};

    // Hand-computed tree sums for the replicated chunks used below.
    function automatic logic [31:0] tree_ref(input logic [255:0] v);
        logic [31:0] w;
        w = v[31:0];
        for (int k = 1; k < 8; k++)
            if (v[32*k +: 32] != w) return 32'hDEAD_BEEF;
        case (w)
            32'h3F80_0000: return 32'h4100_0000; // 8 x 1.0 = 8.0
            32'h4000_0000: return 32'h4180_0000; // 8 x 2.0 = 16.0
            32'h4040_0000: return 32'h41C0_0000; // 8 x 3.0 = 24.0
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Tree model.
    int tree_lat = 10;
    int hold_cycles = 1;
    bit never_finish = 1'b0;
    bit late_req = 1'b0;
    int cnt = 0;
    int hcnt = 0;
    initial begin
        bus.tree_finish = 1'b0;
        bus.tree_sum    = '0;
    end
    always @(posedge clk) begin
        if (bus.tree_start) begin
            cnt             <= tree_lat;
            hcnt            <= 0;
            bus.tree_finish <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !never_finish) begin
                bus.tree_finish <= 1'b1;
                bus.tree_sum    <= tree_ref(bus.tree_inputs);
                hcnt            <= hold_cycles;
            end
        end else if (late_req) begin
            bus.tree_finish <= 1'b1;
            bus.tree_sum    <= 32'h4000_0000;
            hcnt            <= 2;
        end else if (hcnt > 0) begin
            hcnt <= hcnt - 1;
            if (hcnt == 1) bus.tree_finish <= 1'b0;
        end
    end

    // Event counters and timestamps (cycle index of the cycle a signal was high).
    int cyc = 0, n_ts = 0, n_as = 0, n_rd = 0, n_done = 0, n_err = 0;
    int ts_cyc = 0, start_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [7:0] rd_log [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc;
        if (bus.tree_start) begin
            n_ts   <= n_ts + 1;
            ts_cyc <= cyc;
        end
        if (dut.add_start) n_as <= n_as + 1;
        if (bus.rd_en) begin
            rd_log[n_rd % 64] <= bus.rd_addr;
            n_rd <= n_rd + 1;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    task automatic do_start(input logic [7:0] n);
        @(negedge clk);
        start      = 1'b1;
        num_chunks = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"},  bus.rd_en, 1'b0);
        check_eq({tag, "_rd_addr"}, bus.rd_addr, 8'h00);
        check_eq({tag, "_tree_inputs"}, bus.tree_inputs, 256'h0);
        check_eq({tag, "_tree_start"}, bus.tree_start, 1'b0);
        check_eq({tag, "_result"}, result, 32'h0);
        check_eq({tag, "_busy"},  busy, 1'b0);
        check_eq({tag, "_done"},  done, 1'b0);
        check_eq({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int ts0, as0, d0, e0, r0, k;
        logic [255:0] exp_ti;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // One chunk of 1.0 words: sum 8.0, no accumulator add.
        buf_word[0] = FP_ONE;
        ts0 = n_ts; as0 = n_as; d0 = n_done;
        do_start(8'd1);
        wait_idle("t1_idle", 200);
        check_eq("t1_result", result, 32'h4100_0000);
        check_eq("t1_tree_starts", n_ts - ts0, 1);
        check_eq("t1_add_starts", n_as - as0, 0);
        check_eq("t1_done_pulses", n_done - d0, 1);
        exp_ti = {8{FP_ONE}};
        check_eq("t1_tree_inputs", bus.tree_inputs, exp_ti);

        // Zero chunks: done two cycles after start, result 0, no traffic.
        ts0 = n_ts; d0 = n_done; r0 = n_rd;
        do_start(8'd0);
        wait_idle("t3_idle", 20);
        check_eq("t3_result", result, 32'h0);
        check_eq("t3_latency", done_cyc - start_cyc, 2);
        check_eq("t3_rd_en", n_rd - r0, 0);
        check_eq("t3_tree_starts", n_ts - ts0, 0);
        check_eq("t3_done_pulses", n_done - d0, 1);

        // Three chunks of 1.0, 2.0, 3.0: 8 + 16 + 24 = 48.0.
        buf_word[0] = FP_ONE;
        buf_word[1] = 32'h4000_0000;
        buf_word[2] = 32'h4040_0000;
        ts0 = n_ts; as0 = n_as; r0 = n_rd;
        do_start(8'd3);
        wait_idle("t2_idle", 300);
        check_eq("t2_result", result, 32'h4240_0000);
        check_eq("t2_tree_starts", n_ts - ts0, 3);
        check_eq("t2_add_starts", n_as - as0, 2);
        check_eq("t2_rd_count", n_rd - r0, 3);
        check_eq("t2_rd_addr0", rd_log[r0 % 64], 8'd0);
        check_eq("t2_rd_addr1", rd_log[(r0 + 1) % 64], 8'd1);
        check_eq("t2_rd_addr2", rd_log[(r0 + 2) % 64], 8'd2);
        exp_ti = {8{32'h4040_0000}};
        check_eq("t2_tree_inputs", bus.tree_inputs, exp_ti);

        // Tree never finishes: error 255 cycles after tree_start, result kept.
        never_finish = 1'b1;
        e0 = n_err; d0 = n_done;
        do_start(8'd1);
        wait_idle("t4_idle", 400);
        check_eq("t4_error_pulses", n_err - e0, 1);
        check_eq("t4_error_latency", err_cyc - ts_cyc, 255);
        check_eq("t4_result_kept", result, 32'h4240_0000);
        check_eq("t4_no_done", n_done - d0, 0);
        never_finish = 1'b0;
        repeat (3) @(negedge clk);

        // Restart ignored while busy, then reset in WAIT_A.
        buf_word[0] = FP_ONE;
        buf_word[1] = FP_ONE;
        ts0 = n_ts;
        do_start(8'd2);
        k = 0;
        while (n_ts == ts0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        do_start(8'd5);
        k = 0;
        while (!dut.add_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_reach_wait_a", dut.add_start, 1'b1);
        check_eq("t5_tree_starts", n_ts - ts0, 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        @(negedge clk);
        reset = 1'b0;
        ts0 = n_ts; d0 = n_done; e0 = n_err; r0 = n_rd;
        late_req = 1'b1;
        @(negedge clk);
        late_req = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("t5_late_busy", busy, 1'b0);
        check_eq("t5_late_done", n_done - d0, 0);
        check_eq("t5_late_error", n_err - e0, 0);
        check_eq("t5_late_tree_start", n_ts - ts0, 0);
        check_eq("t5_late_rd_en", n_rd - r0, 0);
        check_eq("t5_late_result", result, 32'h0);

        // Finish held high for 5 cycles: each chunk counted once, 8 + 8 = 16.
        hold_cycles = 5;
        ts0 = n_ts; as0 = n_as; d0 = n_done;
        do_start(8'd2);
        wait_idle("t6_idle", 300);
        check_eq("t6_result", result, 32'h4180_0000);
        check_eq("t6_tree_starts", n_ts - ts0, 2);
        check_eq("t6_add_starts", n_as - as0, 1);
        check_eq("t6_done_pulses", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
